memory_rd_arbiter: RTL and testbench
====================================

Name: memory_rd_arbiter

Overview:
- Shares the single read port of the dual-port memory between N requesters using round-robin arbitration.
- Passes one writer straight through to the write port.
- Returns each read response tagged with the requester ID.
- Resolves same-cycle read/write collisions by forwarding, because read-during-write on the memory array is undefined.
- Sits between the client blocks and the memory instance, in the same clock domain as both memory ports.

Parameters:
N, 4, number of read requesters (1..16)
DW, 32, memory data width
DEPTH, 32, memory depth
AW, $clog2(DEPTH), address width
IW, (N>1 ? $clog2(N) : 1), requester ID width

Ports:
clk  input  1  single clock; drives the arbiter and both memory clocks
reset  input  1  asynchronous, active-high reset
pause  input  1  when high, no new read grants are issued
req_valid  input  N  per-requester read request
req_addr  input  N*AW  per-requester read address; requester i uses bits [i*AW +: AW]
req_ready  output  N  one-hot read grant (valid/ready handshake)
wr_valid  input  1  write request
wr_wem  input  DW  per-bit write enable
wr_addr  input  AW  write address
wr_din  input  DW  write data
wr_ready  output  1  write accept; tied to 1
rsp_valid  output  1  read response valid
rsp_id  output  IW  index of the requester that owns the response
rsp_data  output  DW  read response data
mem_wr_en  output  1  to memory wr_en
mem_wr_wem  output  DW  to memory wr_wem
mem_wr_addr  output  AW  to memory wr_addr
mem_wr_din  output  DW  to memory wr_din
mem_rd_en  output  1  to memory rd_en
mem_rd_addr  output  AW  to memory rd_addr
mem_rd_dout  input  DW  from memory rd_dout; one-cycle registered read latency

Behaviour:
- Reset state (async on reset rising, held while high):
  - ptr=0, rsp_valid=0, rsp_id=0.
  - Forward registers (fwd_en, fwd_wem, fwd_din) = 0.
  - Combinational outputs follow their inputs as described below.
  - A response in flight when reset asserts is discarded; no rsp_valid pulse follows reset release.
- Arbitration (combinational, each cycle):
  - If pause=0, grant g = first index i in the order ptr, ptr+1, …, N-1, 0, …, ptr-1 that has req_valid[i]=1.
  - req_ready = onehot(g); at most one bit is ever set.
  - No valid request or pause=1: req_ready=0, mem_rd_en=0.
- Grant cycle t:
  - mem_rd_en=1, mem_rd_addr=req_addr[g].
  - Handshake completes in cycle t; the requester may change its address or deassert in t+1.
- Pointer update: on a grant, ptr <= (g+1) mod N; with no grant, ptr holds.
  - A requester held continuously high is therefore served at most once every N cycles when all N requesters contend.
  - With N=1, ptr stays 0.
- Response timing:
  - rsp_valid=1 in cycle t+1 exactly, with rsp_id=g registered at t.
  - Back-to-back grants give back-to-back responses, one read per cycle at full throughput.
  - There is no response backpressure: requesters must accept rsp in t+1.
- Write path (combinational passthrough, unaffected by pause and by arbitration):
  - mem_wr_en=wr_valid, mem_wr_wem=wr_wem, mem_wr_addr=wr_addr, mem_wr_din=wr_din, wr_ready=1.
- Collision forwarding:
  - If a grant occurs in cycle t with wr_valid=1 and wr_addr==req_addr[g], register fwd_en=1, fwd_wem=wr_wem, fwd_din=wr_din; otherwise register fwd_en=0.
  - In t+1: rsp_data = fwd_en ? ((fwd_din & fwd_wem) | (mem_rd_dout & ~fwd_wem)) : mem_rd_dout.
  - Bits not write-enabled come from the array.
  - A write at t-1 to the same address needs no forwarding; the memory returns the new data.
- rsp_data when rsp_valid=0: don't-care.
- pause:
  - Asserting pause in cycle t blocks a grant in t.
  - A response already granted in t-1 still completes in t.
  - ptr is frozen while paused.
- Request address bits of non-granted requesters are ignored.

Test Plan:
- Reset, then a single read: N=4, preload addr 5 = 0xDEADBEEF; req_valid=0001, addr0=5 -> req_ready=0001 at t; rsp_valid=1, rsp_id=0, rsp_data=0xDEADBEEF at t+1; rsp_valid=0 at t+2.
- Fairness: req_valid=1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3; rsp_id matches each grant one cycle later; no idle cycles.
- Collision: preload addr 3 = 0x00000000; same cycle wr_valid=1, wr_addr=3, wr_din=0xFFFFFFFF, wr_wem=0x0000FFFF, read addr 3 -> rsp_data=0x0000FFFF; a re-read two cycles later also returns 0x0000FFFF.
- Pause: req_valid=0110, ptr=1, pause high for 3 cycles -> req_ready=0 and no rsp during the pause; after release grants go 1, then 2.
- Reset mid-operation: grant at t, reset asserted before t+1 -> rsp_valid stays 0; after release ptr=0, and req_valid=1010 grants requester 1 first.
- Skip and wrap: ptr=3, req_valid=0101 -> requester 0 is granted, then 2; rsp_id sequence 0,2.

Source files
------------

// File: rtl/memory_rd_arbiter_if.sv
// ---------------------------------------------------------------------------
// memory_rd_arbiter_if
// Bundles every signal between memory_rd_arbiter, its client blocks and the
// dual-port memory instance. clk and reset stay plain ports on the arbiter.
//
//   pause              - blocks new read grants while high
//   req_valid/req_addr - per-requester read requests (requester i: [i*AW +: AW])
//   req_ready          - one-hot read grant
//   wr_*               - single writer, passed straight to the write port
//   rsp_valid/id/data  - read response, one cycle after the grant
//   mem_*              - memory port connections (rd_dout has 1-cycle latency)
//
// slave : the arbiter's view.   master : the client/memory side's view.
// ---------------------------------------------------------------------------
interface memory_rd_arbiter_if #(
  parameter int N     = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH),
  parameter int IW    = (N > 1) ? $clog2(N) : 1
);
  logic            pause;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;

  logic            wr_valid;
  logic [DW-1:0]   wr_wem;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_din;
  logic            wr_ready;

  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_data;

  logic            mem_wr_en;
  logic [DW-1:0]   mem_wr_wem;
  logic [AW-1:0]   mem_wr_addr;
  logic [DW-1:0]   mem_wr_din;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_rd_addr;
  logic [DW-1:0]   mem_rd_dout;

  modport slave (
    input  pause, req_valid, req_addr,
    input  wr_valid, wr_wem, wr_addr, wr_din,
    input  mem_rd_dout,
    output req_ready, wr_ready,
    output rsp_valid, rsp_id, rsp_data,
    output mem_wr_en, mem_wr_wem, mem_wr_addr, mem_wr_din,
    output mem_rd_en, mem_rd_addr
  );

  modport master (
    output pause, req_valid, req_addr,
    output wr_valid, wr_wem, wr_addr, wr_din,
    output mem_rd_dout,
    input  req_ready, wr_ready,
    input  rsp_valid, rsp_id, rsp_data,
    input  mem_wr_en, mem_wr_wem, mem_wr_addr, mem_wr_din,
    input  mem_rd_en, mem_rd_addr
  );
endinterface

// File: rtl/memory_rd_arbiter.sv
// ---------------------------------------------------------------------------
// memory_rd_arbiter
// Shares the read port of a dual-port memory between N requesters with
// round-robin arbitration, passes a single writer straight to the write port,
// and returns each read response tagged with the owning requester's ID.
// Read-during-write on the array is undefined, so a same-cycle read/write to
// the same address is resolved by forwarding the written bits.
//
// Ports:
//   clk   - single clock for arbiter and both memory ports
//   reset - asynchronous, active-high
//   bus   - memory_rd_arbiter_if.slave (requests, write, response, memory)
// ---------------------------------------------------------------------------
module memory_rd_arbiter #(
  parameter int N     = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH),
  parameter int IW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  memory_rd_arbiter_if.slave    bus
);

  logic [AW-1:0] addr_arr [N];
  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_nxt;
  logic [IW:0]   scan_idx;
  logic          gnt_vld;
  logic [IW-1:0] gnt_idx;
  logic          collide;

  logic          rsp_valid_q;
  logic [IW-1:0] rsp_id_q;
  logic          fwd_en;
  logic [DW-1:0] fwd_wem;
  logic [DW-1:0] fwd_din;

  for (genvar i = 0; i < N; i++) begin : g_addr
    assign addr_arr[i] = bus.req_addr[i*AW +: AW];
  end

  // Round-robin scan starting at ptr; the extra bit on scan_idx lets the
  // wrap work for N that is not a power of two.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    if (!bus.pause) begin
      for (int k = 0; k < N; k++) begin
        scan_idx = {1'b0, ptr} + (IW+1)'(k);
        if (scan_idx >= (IW+1)'(N)) scan_idx = scan_idx - (IW+1)'(N);
        if (!gnt_vld && bus.req_valid[scan_idx[IW-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_idx = scan_idx[IW-1:0];
        end
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (gnt_vld) bus.req_ready[gnt_idx] = 1'b1;
  end

  assign ptr_nxt = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;

  assign bus.mem_rd_en   = gnt_vld;
  assign bus.mem_rd_addr = addr_arr[gnt_idx];

  // Write path is a pure passthrough, independent of pause and arbitration.
  assign bus.mem_wr_en   = bus.wr_valid;
  assign bus.mem_wr_wem  = bus.wr_wem;
  assign bus.mem_wr_addr = bus.wr_addr;
  assign bus.mem_wr_din  = bus.wr_din;
  assign bus.wr_ready    = 1'b1;

  // Same-cycle read and write to one address: the array's read result is
  // undefined for the written bits, so capture them for the response.
  assign collide = gnt_vld && bus.wr_valid && (bus.wr_addr == addr_arr[gnt_idx]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      fwd_en      <= 1'b0;
      fwd_wem     <= '0;
      fwd_din     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the values
      // from before this edge, regardless of statement order.
      rsp_valid_q <= gnt_vld;
      fwd_en      <= collide;
      if (gnt_vld) begin
        ptr      <= ptr_nxt;
        rsp_id_q <= gnt_idx;
        fwd_wem  <= bus.wr_wem;
        fwd_din  <= bus.wr_din;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = fwd_en ? ((fwd_din & fwd_wem) | (bus.mem_rd_dout & ~fwd_wem))
                                : bus.mem_rd_dout;

endmodule

// File: tb/tb_memory_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_rd_arbiter
// Directed bench for memory_rd_arbiter (N=4, DW=32, DEPTH=32). A small
// memory model with one-cycle read latency returns the old contents on a
// same-cycle read/write, so the arbiter's forwarding is what makes a
// collision read return the new data. Inputs change on the falling edge and
// outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_memory_rd_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  memory_rd_arbiter_if #(.N(N), .DW(DW), .DEPTH(32)) bus ();

  memory_rd_arbiter #(.N(N), .DW(DW), .DEPTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Memory model: registered read, per-bit write enable, old data on collision.
  logic [DW-1:0] mem [32];
  logic [DW-1:0] rd_dout;
  always @(posedge clk) begin
    if (bus.mem_rd_en) rd_dout <= mem[bus.mem_rd_addr];
    if (bus.mem_wr_en)
      mem[bus.mem_wr_addr] <= (bus.mem_wr_din & bus.mem_wr_wem) |
                              (mem[bus.mem_wr_addr] & ~bus.mem_wr_wem);
  end
  assign bus.mem_rd_dout = rd_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    bus.req_addr[i*AW +: AW] = a;
  endtask

  task automatic check_rsp(input string tag, input logic [IW-1:0] id, input logic [31:0] data,
                           input bit chk_data);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'(id));
    if (chk_data) check({tag, "_rsp_data"}, bus.rsp_data, data);
  endtask

  initial begin
    reset         = 1'b1;
    bus.pause     = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_wem    = '0;
    bus.wr_addr   = '0;
    bus.wr_din    = '0;

    // Reset state
    @(negedge clk); #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);

    // Preload through the write passthrough; pause must not affect it
    @(negedge clk);
    reset        = 1'b0;
    bus.pause    = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd5;
    bus.wr_din   = 32'hDEADBEEF;
    bus.wr_wem   = 32'hFFFFFFFF;
    #1;
    check("wr_en", 32'(bus.mem_wr_en), 32'd1);
    check("wr_addr", 32'(bus.mem_wr_addr), 32'd5);
    check("wr_din", bus.mem_wr_din, 32'hDEADBEEF);
    check("wr_wem", bus.mem_wr_wem, 32'hFFFFFFFF);
    @(negedge clk);
    bus.pause   = 1'b0;
    bus.wr_addr = 5'd3;
    bus.wr_din  = 32'h0;

    // Single read of requester 0 at address 5
    @(negedge clk);
    bus.wr_valid  = 1'b0;
    bus.req_valid = 4'b0001;
    set_addr(0, 5'd5);
    #1;
    check("single_ready", 32'(bus.req_ready), 32'b0001);
    check("single_rd_en", 32'(bus.mem_rd_en), 32'd1);
    check("single_rd_addr", 32'(bus.mem_rd_addr), 32'd5);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check_rsp("single", 2'd0, 32'hDEADBEEF, 1'b1);
    check("single_idle_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk); #1;
    check("single_rsp_done", 32'(bus.rsp_valid), 32'd0);

    // Pause with ptr=1 and requesters 1,2 waiting
    @(negedge clk);
    bus.req_valid = 4'b0110;
    bus.pause     = 1'b1;
    set_addr(1, 5'd5);
    set_addr(2, 5'd5);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check("pause_ready", 32'(bus.req_ready), 32'd0);
      check("pause_rd_en", 32'(bus.mem_rd_en), 32'd0);
      check("pause_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    @(negedge clk);
    bus.pause = 1'b0;
    #1;
    check("unpause_g1", 32'(bus.req_ready), 32'b0010);
    check("unpause_no_rsp", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk); #1;
    check("unpause_g2", 32'(bus.req_ready), 32'b0100);
    check_rsp("unpause1", 2'd1, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check_rsp("unpause2", 2'd2, 32'hDEADBEEF, 1'b1);

    // Skip and wrap: ptr=3, requesters 0 and 2
    @(negedge clk);
    bus.req_valid = 4'b0101;
    #1;
    check("wrap_g0", 32'(bus.req_ready), 32'b0001);
    @(negedge clk); #1;
    check("wrap_g2", 32'(bus.req_ready), 32'b0100);
    check_rsp("wrap0", 2'd0, 32'h0, 1'b0);
    // Requester 3 alone brings ptr back to 0
    @(negedge clk);
    bus.req_valid = 4'b1000;
    #1;
    check_rsp("wrap2", 2'd2, 32'h0, 1'b0);
    check("wrap_g3", 32'(bus.req_ready), 32'b1000);

    // Fairness: all four requesting for 8 cycles, distinct addresses
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.req_valid = 4'b1111;
      for (int i = 0; i < N; i++) set_addr(i, 5'(10 + i));
      #1;
      check("fair_ready", 32'(bus.req_ready), 32'(1 << (k % 4)));
      check("fair_rd_addr", 32'(bus.mem_rd_addr), 32'(10 + k % 4));
      check_rsp("fair", 2'((k + 3) % 4), 32'h0, 1'b0);
    end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check_rsp("fair_last", 2'd3, 32'h0, 1'b0);

    // Collision: read addr 3 while writing 0xFFFFFFFF under wem 0x0000FFFF
    @(negedge clk);
    bus.req_valid = 4'b0001;
    set_addr(0, 5'd3);
    bus.wr_valid  = 1'b1;
    bus.wr_addr   = 5'd3;
    bus.wr_din    = 32'hFFFFFFFF;
    bus.wr_wem    = 32'h0000FFFF;
    #1;
    check("coll_ready", 32'(bus.req_ready), 32'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    bus.wr_valid  = 1'b0;
    #1;
    check_rsp("coll", 2'd0, 32'h0000FFFF, 1'b1);
    @(negedge clk);
    bus.req_valid = 4'b0010;
    set_addr(1, 5'd3);
    #1;
    check("reread_ready", 32'(bus.req_ready), 32'b0010);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check_rsp("reread", 2'd1, 32'h0000FFFF, 1'b1);

    // Reset mid-operation: grant then reset before the response edge
    @(negedge clk);
    bus.req_valid = 4'b0001;
    #1;
    check("midrst_grant", 32'(bus.req_ready), 32'b0001);
    #1 reset = 1'b1;
    #1;
    check("midrst_rsp0", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("midrst_rsp1", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_rsp2", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    bus.req_valid = 4'b1010;
    #1;
    check("postrst_g1", 32'(bus.req_ready), 32'b0010);
    @(negedge clk); #1;
    check("postrst_g3", 32'(bus.req_ready), 32'b1000);
    check_rsp("postrst1", 2'd1, 32'h0, 1'b0);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check_rsp("postrst3", 2'd3, 32'h0, 1'b0);
    @(negedge clk); #1;
    check("postrst_idle", 32'(bus.rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
